eth_rx_frame_fifo: RTL and testbench

Store-and-forward receive frame buffer placed directly downstream of the tri-mode MAC receive path, in the `rx_mac_aclk` domain. It accepts the MAC's backpressure-free byte stream and holds each frame until its last byte arrives. It then releases only error-free frames to the user through a standard AXIS master with `tready` backpressure. Frames that end with `rx_axis_mac_tuser` set, or that overflow the buffer, are discarded completely and never appear at the output.

---
 rtl/eth_rx_frame_fifo.sv | 220 ++++++++++++++++++++++
 tb/tb_eth_rx_frame_fifo.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_frame_fifo.sv
// Store-and-forward Ethernet receive frame FIFO: commits whole error-free frames, drops errored/overflowed ones.
// Optional saturating frame statistics counters are enabled with `define ETH_RX_FIFO_STATS_EN.
module eth_rx_frame_fifo #(
    parameter int C_DEPTH = 2048
) (
    input  logic                       rx_mac_aclk,
    input  logic                       rx_mac_reset,
    input  logic [7:0]                 rx_axis_mac_tdata,
    input  logic                       rx_axis_mac_tvalid,
    input  logic                       rx_axis_mac_tlast,
    input  logic                       rx_axis_mac_tuser,
    output logic [7:0]                 m_axis_tdata,
    output logic                       m_axis_tvalid,
    output logic                       m_axis_tlast,
    input  logic                       m_axis_tready,
    output logic                       frame_good,
    output logic                       frame_bad,
    output logic                       frame_ovf,
    output logic [$clog2(C_DEPTH):0]   fifo_level
`ifdef ETH_RX_FIFO_STATS_EN
    ,
    output logic [31:0]                stat_good_cnt,
    output logic [31:0]                stat_bad_cnt,
    output logic [31:0]                stat_ovf_cnt
`endif
);

    localparam int AW = $clog2(C_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_W = PW'(C_DEPTH);
    localparam logic [PW-1:0] ONE_W   = PW'(1);

    logic [8:0]    mem_r [0:C_DEPTH-1];
    logic [8:0]    mem_q_r;
    logic          mem_q_valid_r;
    logic [8:0]    out_r;
    logic          out_valid_r;

    // rd_ptr_r advances only when a byte leaves the output register, so
    // bytes sitting in the prefetch/output stages still occupy buffer space.
    logic [PW-1:0] wr_cur_r;
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] fetch_ptr_r;
    logic [PW-1:0] level_r;
    logic          ovf_flag_r;
    logic          good_r;
    logic          bad_r;
    logic          ovf_r;

    logic          space_s;
    logic          wr_en_s;
    logic [PW-1:0] wr_cur_nxt_s;
    logic [PW-1:0] wr_ptr_nxt_s;
    logic          ovf_flag_nxt_s;
    logic          good_s;
    logic          bad_s;
    logic          ovf_s;
    logic          rd_en_s;
    logic          q_move_s;
    logic          out_take_s;
    logic [PW-1:0] rd_ptr_nxt_s;
    logic [PW-1:0] fetch_ptr_nxt_s;
    logic          mem_q_valid_nxt_s;
    logic          out_valid_nxt_s;

    // Write side: space check, speculative write pointer, commit/rollback decision.
    always_comb begin
        space_s        = ((wr_cur_r - rd_ptr_r) < DEPTH_W);
        wr_en_s        = rx_axis_mac_tvalid && !ovf_flag_r && space_s;
        wr_cur_nxt_s   = wr_cur_r;
        wr_ptr_nxt_s   = wr_ptr_r;
        ovf_flag_nxt_s = ovf_flag_r;
        good_s         = 1'b0;
        bad_s          = 1'b0;
        ovf_s          = 1'b0;
        if (rx_axis_mac_tvalid) begin
            if (rx_axis_mac_tlast) begin
                ovf_flag_nxt_s = 1'b0;
                if (ovf_flag_r || !space_s) begin
                    wr_cur_nxt_s = wr_ptr_r;
                    ovf_s        = 1'b1;
                end else if (rx_axis_mac_tuser) begin
                    wr_cur_nxt_s = wr_ptr_r;
                    bad_s        = 1'b1;
                end else begin
                    wr_cur_nxt_s = wr_cur_r + ONE_W;
                    wr_ptr_nxt_s = wr_cur_r + ONE_W;
                    good_s       = 1'b1;
                end
            end else if (wr_en_s) begin
                wr_cur_nxt_s = wr_cur_r + ONE_W;
            end else begin
                ovf_flag_nxt_s = 1'b1;
            end
        end else begin
            wr_cur_nxt_s = wr_cur_r;
        end
    end

    // Read side: fetch committed bytes into the prefetch stage, then into the output register.
    always_comb begin
        out_take_s        = out_valid_r && m_axis_tready;
        q_move_s          = mem_q_valid_r && (!out_valid_r || m_axis_tready);
        rd_en_s           = (fetch_ptr_r != wr_ptr_r) && (!mem_q_valid_r || q_move_s);
        fetch_ptr_nxt_s   = fetch_ptr_r;
        rd_ptr_nxt_s      = rd_ptr_r;
        mem_q_valid_nxt_s = mem_q_valid_r;
        out_valid_nxt_s   = out_valid_r;
        if (rd_en_s) begin
            fetch_ptr_nxt_s   = fetch_ptr_r + ONE_W;
            mem_q_valid_nxt_s = 1'b1;
        end else if (q_move_s) begin
            mem_q_valid_nxt_s = 1'b0;
        end else begin
            mem_q_valid_nxt_s = mem_q_valid_r;
        end
        if (q_move_s) begin
            out_valid_nxt_s = 1'b1;
        end else if (out_take_s) begin
            out_valid_nxt_s = 1'b0;
        end else begin
            out_valid_nxt_s = out_valid_r;
        end
        if (out_take_s) begin
            rd_ptr_nxt_s = rd_ptr_r + ONE_W;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
    end

    // Frame storage: write port on the MAC side, registered read port for prefetch.
    always_ff @(posedge rx_mac_aclk) begin
        if (wr_en_s) begin
            mem_r[wr_cur_r[AW-1:0]] <= {rx_axis_mac_tlast, rx_axis_mac_tdata};
        end
        if (rd_en_s) begin
            mem_q_r <= mem_r[fetch_ptr_r[AW-1:0]];
        end
    end

    // Control state, status pulses and output register.
    always_ff @(posedge rx_mac_aclk) begin
        if (rx_mac_reset) begin
            wr_cur_r      <= {PW{1'b0}};
            wr_ptr_r      <= {PW{1'b0}};
            rd_ptr_r      <= {PW{1'b0}};
            fetch_ptr_r   <= {PW{1'b0}};
            level_r       <= {PW{1'b0}};
            ovf_flag_r    <= 1'b0;
            good_r        <= 1'b0;
            bad_r         <= 1'b0;
            ovf_r         <= 1'b0;
            mem_q_valid_r <= 1'b0;
            out_valid_r   <= 1'b0;
            out_r         <= 9'd0;
        end else begin
            wr_cur_r      <= wr_cur_nxt_s;
            wr_ptr_r      <= wr_ptr_nxt_s;
            rd_ptr_r      <= rd_ptr_nxt_s;
            fetch_ptr_r   <= fetch_ptr_nxt_s;
            level_r       <= wr_ptr_nxt_s - rd_ptr_nxt_s;
            ovf_flag_r    <= ovf_flag_nxt_s;
            good_r        <= good_s;
            bad_r         <= bad_s;
            ovf_r         <= ovf_s;
            mem_q_valid_r <= mem_q_valid_nxt_s;
            out_valid_r   <= out_valid_nxt_s;
            if (q_move_s) begin
                out_r <= mem_q_r;
            end
        end
    end

    assign m_axis_tdata  = out_r[7:0];
    assign m_axis_tlast  = out_r[8];
    assign m_axis_tvalid = out_valid_r;
    assign frame_good    = good_r;
    assign frame_bad     = bad_r;
    assign frame_ovf     = ovf_r;
    assign fifo_level    = level_r;

`ifdef ETH_RX_FIFO_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        if (value == 32'hFFFF_FFFF) begin
            return value;
        end else begin
            return value + 32'd1;
        end
    endfunction

    logic [31:0] good_cnt_r;
    logic [31:0] bad_cnt_r;
    logic [31:0] ovf_cnt_r;

    // Saturating per-outcome frame counters.
    always_ff @(posedge rx_mac_aclk) begin
        if (rx_mac_reset) begin
            good_cnt_r <= 32'd0;
            bad_cnt_r  <= 32'd0;
            ovf_cnt_r  <= 32'd0;
        end else begin
            if (good_r) begin
                good_cnt_r <= sat_inc(good_cnt_r);
            end
            if (bad_r) begin
                bad_cnt_r <= sat_inc(bad_cnt_r);
            end
            if (ovf_r) begin
                ovf_cnt_r <= sat_inc(ovf_cnt_r);
            end
        end
    end

    assign stat_good_cnt = good_cnt_r;
    assign stat_bad_cnt  = bad_cnt_r;
    assign stat_ovf_cnt  = ovf_cnt_r;
`endif

endmodule

// File: tb/tb_eth_rx_frame_fifo.sv
// Self-checking bench for eth_rx_frame_fifo: scoreboard of expected output bytes vs. monitored transfers.
module tb_eth_rx_frame_fifo;

    localparam int C_DEPTH = 2048;
    localparam int PW = $clog2(C_DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rx_mac_reset = 1'b1;
    logic [7:0]    rx_tdata = 8'd0;
    logic          rx_tvalid = 1'b0;
    logic          rx_tlast = 1'b0;
    logic          rx_tuser = 1'b0;
    logic [7:0]    m_tdata;
    logic          m_tvalid;
    logic          m_tlast;
    logic          m_tready = 1'b0;
    logic          frame_good;
    logic          frame_bad;
    logic          frame_ovf;
    logic [PW-1:0] fifo_level;
`ifdef ETH_RX_FIFO_STATS_EN
    logic [31:0]   stat_good_cnt;
    logic [31:0]   stat_bad_cnt;
    logic [31:0]   stat_ovf_cnt;
`endif

    eth_rx_frame_fifo #(.C_DEPTH(C_DEPTH)) dut (
        .rx_mac_aclk        (clk),
        .rx_mac_reset       (rx_mac_reset),
        .rx_axis_mac_tdata  (rx_tdata),
        .rx_axis_mac_tvalid (rx_tvalid),
        .rx_axis_mac_tlast  (rx_tlast),
        .rx_axis_mac_tuser  (rx_tuser),
        .m_axis_tdata       (m_tdata),
        .m_axis_tvalid      (m_tvalid),
        .m_axis_tlast       (m_tlast),
        .m_axis_tready      (m_tready),
        .frame_good         (frame_good),
        .frame_bad          (frame_bad),
        .frame_ovf          (frame_ovf),
        .fifo_level         (fifo_level)
`ifdef ETH_RX_FIFO_STATS_EN
        ,
        .stat_good_cnt      (stat_good_cnt),
        .stat_bad_cnt       (stat_bad_cnt),
        .stat_ovf_cnt       (stat_ovf_cnt)
`endif
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [8:0] exp_q[$];
    logic [8:0] obs_q[$];
    int         good_seen = 0;
    int         bad_seen = 0;
    int         ovf_seen = 0;
    int         multi_pulse = 0;
    int         stall_viol = 0;
    bit         rand_ready = 1'b0;
    bit         prev_stall = 1'b0;
    logic [8:0] prev_out = 9'd0;

    // Output monitor: records transfers, counts pulses, checks stall stability.
    always @(negedge clk) begin
        if (m_tvalid && m_tready) obs_q.push_back({m_tlast, m_tdata});
        good_seen += int'(frame_good);
        bad_seen  += int'(frame_bad);
        ovf_seen  += int'(frame_ovf);
        if (int'(frame_good) + int'(frame_bad) + int'(frame_ovf) > 1) multi_pulse++;
        if (prev_stall && !rx_mac_reset && !(m_tvalid && {m_tlast, m_tdata} == prev_out)) stall_viol++;
        prev_stall = m_tvalid && !m_tready;
        prev_out   = {m_tlast, m_tdata};
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) m_tready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_frame(input int len, input logic err, input logic [7:0] start,
                              input bit rnd, input bit push);
        logic [7:0] d;
        for (int i = 0; i < len; i++) begin
            d = rnd ? 8'($urandom) : 8'(start + 8'(i));
            rx_tdata  = d;
            rx_tvalid = 1'b1;
            rx_tlast  = (i == len - 1);
            rx_tuser  = (i == len - 1) ? err : 1'b0;
            if (push) exp_q.push_back({rx_tlast, d});
            tick();
        end
        rx_tvalid = 1'b0;
        rx_tlast  = 1'b0;
        rx_tuser  = 1'b0;
    endtask

    task automatic drain(input int expn, output bit ok);
        rand_ready = 1'b0;
        m_tready   = 1'b1;
        for (int w = 0; w < 10000 && obs_q.size() < expn; w++) tick();
        for (int w = 0; w < 8; w++) tick();
        ok = (obs_q.size() == expn);
    endtask

    task automatic test_reset();
        rx_mac_reset = 1'b1;
        tick();
        n_checks += 7;
        if (m_tvalid !== 1'b0)   begin n_errors++; $display("FAIL reset_tvalid: got %b expected 0", m_tvalid); end
        if (m_tlast !== 1'b0)    begin n_errors++; $display("FAIL reset_tlast: got %b expected 0", m_tlast); end
        if (m_tdata !== 8'h00)   begin n_errors++; $display("FAIL reset_tdata: got %h expected 00", m_tdata); end
        if (frame_good !== 1'b0) begin n_errors++; $display("FAIL reset_good: got %b expected 0", frame_good); end
        if (frame_bad !== 1'b0)  begin n_errors++; $display("FAIL reset_bad: got %b expected 0", frame_bad); end
        if (frame_ovf !== 1'b0)  begin n_errors++; $display("FAIL reset_ovf: got %b expected 0", frame_ovf); end
        if (fifo_level !== '0)   begin n_errors++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
        rx_mac_reset = 1'b0;
        tick();
    endtask

    task automatic test_good_frame();
        int g0 = good_seen;
        int expn;
        bit ok;
        logic [8:0] e, o;
        m_tready = 1'b1;
        send_frame(64, 1'b0, 8'h00, 1'b0, 1'b1);
        n_checks += 2;
        if (frame_good !== 1'b1) begin n_errors++; $display("FAIL good_pulse_edge: got %b expected 1", frame_good); end
        if (m_tvalid !== 1'b0)   begin n_errors++; $display("FAIL good_lat_n0: got %b expected 0", m_tvalid); end
        tick();
        n_checks++;
        if (m_tvalid !== 1'b0) begin n_errors++; $display("FAIL good_lat_n1: got %b expected 0", m_tvalid); end
        tick();
        n_checks++;
        if ({m_tvalid, m_tdata} !== 9'h100) begin n_errors++; $display("FAIL good_lat_n2: got %h expected 100", {m_tvalid, m_tdata}); end
        expn = exp_q.size();
        drain(expn, ok);
        n_checks += 2;
        if (!ok) begin n_errors++; $display("FAIL good_count: got %0d expected %0d", obs_q.size(), expn); end
        if (good_seen - g0 != 1) begin n_errors++; $display("FAIL good_pulses: got %0d expected 1", good_seen - g0); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin n_errors++; $display("FAIL good_data: got %h expected %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_bad_frame();
        int b0 = bad_seen;
        m_tready = 1'b1;
        send_frame(64, 1'b1, 8'h40, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        n_checks += 3;
        if (bad_seen - b0 != 1) begin n_errors++; $display("FAIL bad_pulses: got %0d expected 1", bad_seen - b0); end
        if (fifo_level !== '0)  begin n_errors++; $display("FAIL bad_level: got %0d expected 0", fifo_level); end
        if (obs_q.size() != 0)  begin n_errors++; $display("FAIL bad_output: got %0d bytes expected 0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_mixed();
        int expn;
        bit ok;
        logic [8:0] e, o;
        m_tready = 1'b0;
        send_frame(60, 1'b0, 8'h10, 1'b0, 1'b1);
        send_frame(100, 1'b1, 8'h80, 1'b0, 1'b0);
        send_frame(1, 1'b0, 8'hA5, 1'b0, 1'b1);
        tick(); tick();
        n_checks += 2;
        if (fifo_level !== PW'(61)) begin n_errors++; $display("FAIL mixed_level: got %0d expected 61", fifo_level); end
        if (m_tvalid !== 1'b1)      begin n_errors++; $display("FAIL mixed_hold_valid: got %b expected 1", m_tvalid); end
        expn = exp_q.size();
        drain(expn, ok);
        n_checks++;
        if (!ok) begin n_errors++; $display("FAIL mixed_count: got %0d expected %0d", obs_q.size(), expn); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin n_errors++; $display("FAIL mixed_data: got %h expected %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_overflow();
        int o0 = ovf_seen;
        int g0 = good_seen;
        int expn;
        bit ok;
        logic [8:0] e, o;
        m_tready = 1'b0;
        send_frame(C_DEPTH + 1, 1'b0, 8'h00, 1'b1, 1'b0);
        tick();
        n_checks += 2;
        if (ovf_seen - o0 != 1) begin n_errors++; $display("FAIL ovf_long_pulse: got %0d expected 1", ovf_seen - o0); end
        if (fifo_level !== '0)  begin n_errors++; $display("FAIL ovf_long_level: got %0d expected 0", fifo_level); end
        send_frame(C_DEPTH, 1'b0, 8'h00, 1'b1, 1'b1);
        tick();
        n_checks += 2;
        if (fifo_level !== PW'(C_DEPTH)) begin n_errors++; $display("FAIL ovf_full_level: got %0d expected %0d", fifo_level, C_DEPTH); end
        if (good_seen - g0 != 1)         begin n_errors++; $display("FAIL ovf_full_pulse: got %0d expected 1", good_seen - g0); end
        send_frame(1, 1'b0, 8'h77, 1'b0, 1'b0);
        tick();
        n_checks += 2;
        if (ovf_seen - o0 != 2)          begin n_errors++; $display("FAIL ovf_single_pulse: got %0d expected 2", ovf_seen - o0); end
        if (fifo_level !== PW'(C_DEPTH)) begin n_errors++; $display("FAIL ovf_single_level: got %0d expected %0d", fifo_level, C_DEPTH); end
        expn = exp_q.size();
        drain(expn, ok);
        n_checks++;
        if (!ok) begin n_errors++; $display("FAIL ovf_count: got %0d expected %0d", obs_q.size(), expn); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin n_errors++; $display("FAIL ovf_data: got %h expected %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_back_to_back();
        int g0 = good_seen;
        int o0 = ovf_seen;
        int ngood = 0;
        int len, expn;
        bit err, ok;
        logic [8:0] e, o;
        stall_viol = 0;
        rand_ready = 1'b1;
        for (int f = 0; f < 200; f++) begin
            len = (f % 100 == 0) ? 1518 : $urandom_range(1, 160);
            err = ($urandom_range(0, 7) == 0);
            for (int w = 0; w < 8000 && int'(fifo_level) + len > C_DEPTH; w++) tick();
            if (int'(fifo_level) + len > C_DEPTH) begin
                n_checks++; n_errors++;
                $display("FAIL b2b_pace_timeout: level %0d frame %0d", fifo_level, f);
            end
            send_frame(len, err, 8'h00, 1'b1, !err);
            if (!err) ngood++;
        end
        expn = exp_q.size();
        drain(expn, ok);
        n_checks += 6;
        if (!ok)                     begin n_errors++; $display("FAIL b2b_count: got %0d expected %0d", obs_q.size(), expn); end
        if (good_seen - g0 != ngood) begin n_errors++; $display("FAIL b2b_good_pulses: got %0d expected %0d", good_seen - g0, ngood); end
        if (ovf_seen - o0 != 0)      begin n_errors++; $display("FAIL b2b_ovf_pulses: got %0d expected 0", ovf_seen - o0); end
        if (stall_viol != 0)         begin n_errors++; $display("FAIL b2b_stall_stable: got %0d violations expected 0", stall_viol); end
        if (multi_pulse != 0)        begin n_errors++; $display("FAIL b2b_pulse_excl: got %0d expected 0", multi_pulse); end
        if (fifo_level !== '0)       begin n_errors++; $display("FAIL b2b_level: got %0d expected 0", fifo_level); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin n_errors++; $display("FAIL b2b_data: got %h expected %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_mid_frame();
        int g0, expn;
        bit ok;
        logic [8:0] e, o;
        m_tready = 1'b0;
        send_frame(20, 1'b0, 8'h30, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) begin
            rx_tdata = 8'(i); rx_tvalid = 1'b1; rx_tlast = 1'b0; rx_tuser = 1'b0;
            tick();
        end
        rx_tdata = 8'd30;
        rx_mac_reset = 1'b1;
        tick();
        n_checks += 7;
        if (m_tvalid !== 1'b0)   begin n_errors++; $display("FAIL mid_tvalid: got %b expected 0", m_tvalid); end
        if (m_tlast !== 1'b0)    begin n_errors++; $display("FAIL mid_tlast: got %b expected 0", m_tlast); end
        if (m_tdata !== 8'h00)   begin n_errors++; $display("FAIL mid_tdata: got %h expected 00", m_tdata); end
        if (frame_good !== 1'b0) begin n_errors++; $display("FAIL mid_good: got %b expected 0", frame_good); end
        if (frame_bad !== 1'b0)  begin n_errors++; $display("FAIL mid_bad: got %b expected 0", frame_bad); end
        if (frame_ovf !== 1'b0)  begin n_errors++; $display("FAIL mid_ovf: got %b expected 0", frame_ovf); end
        if (fifo_level !== '0)   begin n_errors++; $display("FAIL mid_level: got %0d expected 0", fifo_level); end
        rx_mac_reset = 1'b0;
        rx_tvalid = 1'b0;
        exp_q.delete(); obs_q.delete();
        tick();
        g0 = good_seen;
        m_tready = 1'b1;
        send_frame(64, 1'b0, 8'hC0, 1'b0, 1'b1);
        expn = exp_q.size();
        drain(expn, ok);
        n_checks += 2;
        if (!ok)                 begin n_errors++; $display("FAIL mid_count: got %0d expected %0d", obs_q.size(), expn); end
        if (good_seen - g0 != 1) begin n_errors++; $display("FAIL mid_good_pulse: got %0d expected 1", good_seen - g0); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin n_errors++; $display("FAIL mid_data: got %h expected %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        for (int i = 0; i < 3; i++) tick();
        test_reset();
        test_good_frame();
        test_bad_frame();
        test_mixed();
        test_overflow();
        test_back_to_back();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
